// File: rtl/calendar_sequencer.sv
// Calendar date sequencer: loads and validates a start date, then advances it
// by one day per tick, tracking month length, leap year and month rollover.
module calendar_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] d_in,
  input  logic [3:0] m_in,
  input  logic [6:0] y_in,
  input  logic       tick,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       m28,
  output logic       m29,
  output logic       m30,
  output logic       m31,
  output logic       leap,
  output logic       month_end,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       from_run_q;      // CHECK was entered from RUN (return target on reject)
  logic [4:0] ld_day_q;
  logic [3:0] ld_mon_q;
  logic [6:0] ld_year_q;

  logic       capture, commit, reject, advance;
  logic       ld_leap, ld_valid;
  logic [4:0] ld_len, cur_len;
  logic [4:0] adv_day;
  logic [3:0] adv_month;
  logic [6:0] adv_year;
  logic       adv_leap, adv_rollover;
  logic [4:0] adv_len;

  // Year offset 0 is 2000 (leap); offset 100 is 2100 (not leap).
  function automatic logic is_leap(input logic [6:0] y);
    return (y[1:0] == 2'b00) && (y != 7'd100);
  endfunction

  // Days in month m; out-of-range months are rejected separately by the validity check.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return lp ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Validate the captured load request and size the current month.
  always_comb begin
    ld_leap  = is_leap(ld_year_q);
    ld_len   = month_len(ld_mon_q, ld_leap);
    ld_valid = (ld_mon_q >= 4'd1) && (ld_mon_q <= 4'd12) &&
               (ld_day_q != 5'd0) && (ld_day_q <= ld_len);
    cur_len  = month_len(month, leap);
  end

  // Compute the date one day after the current one.
  always_comb begin
    adv_day      = day + 5'd1;
    adv_month    = month;
    adv_year     = year;
    adv_rollover = 1'b0;
    if (day == cur_len) begin
      adv_day      = 5'd1;
      adv_rollover = 1'b1;
      if (month == 4'd12) begin
        adv_month = 4'd1;
        adv_year  = year + 7'd1;  // 127 wraps to 0
      end else begin
        adv_month = month + 4'd1;
      end
    end
    adv_leap = is_leap(adv_year);
    adv_len  = month_len(adv_month, adv_leap);
  end

  // Next-state and control decode; load wins over tick, ticks outside RUN are dropped.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    busy    = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    reject  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (ld_valid) begin
          commit  = 1'b1;
          state_d = RUN;
        end else begin
          reject  = 1'b1;
          state_d = from_run_q ? RUN : IDLE;
        end
      end
      RUN: begin
        if (load) begin
          capture = 1'b1;
          state_d = CHECK;
        end else if (tick) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the return target for a rejected load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= IDLE;
      from_run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) from_run_q <= (state_q == RUN);
    end
  end

  // Hold the requested date for the one-cycle check.
  always_ff @(posedge clk) begin
    // NOTE: no reset needed here; these are only read in CHECK, which always follows a capture.
    if (capture) begin
      ld_day_q  <= d_in;
      ld_mon_q  <= m_in;
      ld_year_q <= y_in;
    end
  end

  // Date, month-length flags, leap, rollover pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      day       <= 5'd1;
      month     <= 4'd1;
      year      <= 7'd0;
      leap      <= 1'b1;
      m28       <= 1'b0;
      m29       <= 1'b0;
      m30       <= 1'b0;
      m31       <= 1'b0;
      month_end <= 1'b0;
      err       <= 1'b0;
    end else begin
      month_end <= 1'b0;
      if (commit) begin
        day   <= ld_day_q;
        month <= ld_mon_q;
        year  <= ld_year_q;
        leap  <= ld_leap;
        m28   <= (ld_len == 5'd28);
        m29   <= (ld_len == 5'd29);
        m30   <= (ld_len == 5'd30);
        m31   <= (ld_len == 5'd31);
        err   <= 1'b0;
      end else if (reject) begin
        err <= 1'b1;
      end else if (advance) begin
        day       <= adv_day;
        month     <= adv_month;
        year      <= adv_year;
        leap      <= adv_leap;
        m28       <= (adv_len == 5'd28);
        m29       <= (adv_len == 5'd29);
        m30       <= (adv_len == 5'd30);
        m31       <= (adv_len == 5'd31);
        month_end <= adv_rollover;
      end
    end
  end

endmodule

// File: tb/tb_calendar_sequencer.sv
// Self-checking bench for calendar_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a date model.
module tb_calendar_sequencer;

  logic       clk = 1'b0;
  logic       rst, load, tick;
  logic [4:0] d_in;
  logic [3:0] m_in;
  logic [6:0] y_in;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       m28, m29, m30, m31, leap, month_end, busy, err;

  int checks   = 0;
  int failures = 0;

  calendar_sequencer dut (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .m_in(m_in), .y_in(y_in),
    .tick(tick), .day(day), .month(month), .year(year),
    .m28(m28), .m29(m29), .m30(m30), .m31(m31), .leap(leap),
    .month_end(month_end), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (calendar arithmetic) ----------------
  function automatic bit mdl_leap(input int y);
    return ((y % 4) == 0) && (y != 100);
  endfunction

  function automatic int days_in(input int m, input int y);
    case (m)
      1, 3, 5, 7, 8, 10, 12: return 31;
      4, 6, 9, 11:           return 30;
      2:                     return mdl_leap(y) ? 29 : 28;
      default:               return 0;
    endcase
  endfunction

  // mode: 0 idle, 1 checking, 2 running
  bit mdl_valid = 0;
  int mode, md, mm, my, pd, pm, py;
  bit ret_run, on, m_err, m_me;

  always @(posedge clk) begin
    if (rst) begin
      mdl_valid = 1; mode = 0; md = 1; mm = 1; my = 0;
      m_err = 0; m_me = 0; on = 0; ret_run = 0;
    end else if (mdl_valid) begin
      m_me = 0;
      if (mode == 1) begin
        if (pm >= 1 && pm <= 12 && pd >= 1 && pd <= days_in(pm, py)) begin
          md = pd; mm = pm; my = py; m_err = 0; on = 1; mode = 2;
        end else begin
          m_err = 1; mode = ret_run ? 2 : 0;
        end
      end else if (load) begin
        pd = d_in; pm = m_in; py = y_in; ret_run = (mode == 2); mode = 1;
      end else if (mode == 2 && tick) begin
        md++;
        if (md > days_in(mm, my)) begin
          md = 1; mm++; m_me = 1;
          if (mm > 12) begin mm = 1; my = (my + 1) % 128; end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (mdl_valid) begin
      int len;
      len = on ? days_in(mm, my) : 0;
      check("cmp_day", day, md);
      check("cmp_month", month, mm);
      check("cmp_year", year, my);
      check("cmp_leap", leap, mdl_leap(my));
      check("cmp_m28", m28, len == 28);
      check("cmp_m29", m29, len == 29);
      check("cmp_m30", m30, len == 30);
      check("cmp_m31", m31, len == 31);
      check("cmp_month_end", month_end, m_me);
      check("cmp_busy", busy, mode == 1);
      check("cmp_err", err, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, input bit l, input bit t, input int d, input int m, input int y);
    rst = r; load = l; tick = t;
    d_in = 5'(d); m_in = 4'(m); y_in = 7'(y);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_load(input int d, input int m, input int y);
    cyc(0, 1, 0, d, m, y);
    idle();
  endtask

  task automatic expect_date(input string name, input int d, input int m, input int y);
    check({name, "_day"}, day, d);
    check({name, "_month"}, month, m);
    check({name, "_year"}, year, y);
  endtask

  task automatic expect_flags(input string name, input int f);  // f = {m28,m29,m30,m31}
    check(name, {m28, m29, m30, m31}, f);
  endtask

  initial begin
    int r, d, m, y;
    rst = 1; load = 0; tick = 0; d_in = 0; m_in = 0; y_in = 0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    expect_date("rst", 1, 1, 0);
    check("rst_leap", leap, 1);
    expect_flags("rst_flags", 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // Ticks in IDLE are dropped
    repeat (3) cyc(0, 0, 1, 0, 0, 0);
    expect_date("idle_tick", 1, 1, 0);

    // Leap February
    cyc(0, 1, 0, 28, 2, 24);
    check("load_busy", busy, 1);
    idle();
    expect_date("leap_load", 28, 2, 24);
    check("leap_leap", leap, 1);
    expect_flags("leap_m29", 4'b0100);
    cyc(0, 0, 1, 0, 0, 0);
    expect_date("leap_t1", 29, 2, 24);
    check("leap_t1_me", month_end, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_date("leap_t2", 1, 3, 24);
    check("leap_t2_me", month_end, 1);
    expect_flags("leap_m31", 4'b0001);
    idle();
    check("leap_me_drop", month_end, 0);

    // Non-leap February of year 100
    do_load(28, 2, 100);
    check("y100_leap", leap, 0);
    expect_flags("y100_m28", 4'b1000);
    cyc(0, 0, 1, 0, 0, 0);
    expect_date("y100_t1", 1, 3, 100);
    check("y100_me", month_end, 1);
    idle();
    check("y100_me_drop", month_end, 0);

    // Year wrap
    do_load(31, 12, 127);
    check("wrap_leap0", leap, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_date("wrap", 1, 1, 0);
    check("wrap_leap", leap, 1);
    check("wrap_me", month_end, 1);

    // Invalid loads from IDLE
    cyc(1, 0, 0, 0, 0, 0);
    do_load(31, 4, 5);
    check("inv1_err", err, 1);
    expect_date("inv1", 1, 1, 0);
    check("inv1_busy", busy, 0);
    do_load(0, 1, 5);
    check("inv2_err", err, 1);
    do_load(30, 4, 5);
    check("inv3_err", err, 0);
    expect_date("inv3", 30, 4, 5);
    expect_flags("inv3_m30", 4'b0010);

    // Load/tick collision in RUN
    do_load(10, 6, 7);
    cyc(0, 1, 1, 1, 1, 1);
    idle();
    expect_date("collide", 1, 1, 1);

    // Reset during CHECK abandons the load
    cyc(0, 1, 0, 15, 8, 9);
    check("midrst_busy_pre", busy, 1);
    cyc(1, 0, 0, 0, 0, 0);
    expect_date("midrst", 1, 1, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    expect_flags("midrst_flags", 4'b0000);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 5);
      d = (r == 0) ? $urandom_range(0, 31) : (r == 5 ? 1 : 27 + r);
      m = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
      case ($urandom_range(0, 3))
        0: y = 0;
        1: y = 100;
        2: y = 127;
        default: y = $urandom_range(0, 127);
      endcase
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) != 0, d, m, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calendar_sequencer.md
CALENDAR_SEQUENCER -- requirements
Module: calendar_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port load, input, 1 bit: request to load a start date from d_in/m_in/y_in.
REQ-004 SHALL have ports d_in[4:0], m_in[3:0], y_in[6:0], inputs: day 1-31, month 1-12, and year offset 0-127 (2000-2127).
REQ-005 SHALL have port tick, input, 1 bit: advance the date by one day.
REQ-006 SHALL have ports day[4:0], month[3:0], year[6:0], outputs, registered: current date.
REQ-007 SHALL have ports m28, m29, m30, m31, outputs, 1 bit each, registered: one-hot length of the current month.
REQ-008 SHALL have port leap, output, 1 bit, registered: the current year is a leap year.
REQ-009 SHALL have port month_end, output, 1 bit: one-cycle pulse when a tick rolls the month over.
REQ-010 SHALL have port busy, output, 1 bit: high while a load is being checked; tick is ignored while high.
REQ-011 SHALL have port err, output, 1 bit, sticky: the last load was an invalid date.

Function
REQ-012 SHALL implement the states IDLE, CHECK and RUN.
REQ-013 SHALL transition as follows:
- IDLE: load -> CHECK; tick is ignored.
- CHECK, exactly 1 cycle, busy=1: if the date is valid, write the date, clear err and go to RUN; if invalid, keep the prior date, set err and return to the prior state (IDLE or RUN).
- RUN: load -> CHECK; otherwise tick advances the date.
REQ-014 SHALL treat a load as valid only when m_in is 1-12, d_in is at least 1, and d_in does not exceed the length of month m_in in year y_in.
REQ-015 SHALL compute leap as (year[1:0]==0) and (year!=100); so 2000 is a leap year and 2100 is not.
REQ-016 SHALL define month lengths as:
- 31 days: months 1,3,5,7,8,10,12.
- 30 days: months 4,6,9,11.
- month 2: 29 days if leap, else 28.
REQ-017 SHALL drive exactly one of m28/m29/m30/m31 high whenever in RUN, and all four low in IDLE.
REQ-018 SHALL advance on a tick in RUN as follows; the new date is visible one cycle after the tick cycle:
- not the last day of the month: day+1.
- last day of the month: day=1 and month+1, with month_end=1 that cycle.
- Dec 31: day=1, month=1, year+1, with month_end=1.
REQ-019 SHALL wrap year 127 Dec 31 + tick to year 0 Jan 1, with month_end=1.
REQ-020 SHALL update leap and m28-m31 in the same cycle as the date registers they describe.
REQ-021 SHALL give load priority over tick when both are asserted in the same cycle in RUN; that tick is dropped.
REQ-022 SHALL drop, not queue, any tick asserted in IDLE or CHECK.
REQ-023 SHALL hold month_end low in every cycle except the rollover cycle defined in REQ-018.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set: state IDLE, day=1, month=1, year=0, leap=1, m28-m31=0, month_end=0, busy=0, err=0.
REQ-025 SHALL give rst priority over load and tick.
REQ-026 SHALL abandon a load in progress if rst is asserted during CHECK, with no date written.

Verification
REQ-027 SHALL cover a valid load followed by ticks: load 28/2/24 -> RUN, leap=1, m29=1; tick -> 29/2/24; tick -> 1/3/24 with month_end=1 and m31=1.
REQ-028 SHALL cover a non-leap February: load 28/2/100 -> leap=0, m28=1; tick -> 1/3/100 with month_end pulsed for exactly 1 cycle.
REQ-029 SHALL cover year wrap: load 31/12/127, then tick -> 1/1/0, leap=1, month_end=1.
REQ-030 SHALL cover invalid loads: load 31/4/5 -> err=1 with the date unchanged; then load 0/1/5 -> err stays 1; then load 30/4/5 -> err=0 and date 30/4/5.
REQ-031 SHALL cover load/tick collision and IDLE ticks: in RUN at 10/6/7, load 1/1/1 and tick together -> 1/1/1, tick ignored; ticks in IDLE after reset -> date stays 1/1/0.
REQ-032 SHALL cover reset mid-operation: rst in the CHECK cycle -> next cycle in IDLE at 1/1/0 with busy=0, err=0, and m28-m31 all 0.
